// File: rtl/oven_timer_ctrl.sv
// ---------------------------------------------------------------------------
// oven_timer_ctrl
//   Cook-timer controller. The user types mm:ss digits from the switch bank
//   with the enter button, and the start button begins the countdown. The
//   time then counts down one second per tick_1hz, the heater is gated, the
//   door pauses the countdown, and a timed beep sounds at the end.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   tick_1hz          one-clk pulse per second
//   digit_in[3:0]     BCD digit from the switches (values above 9 are ignored)
//   enter_btn         rising edge shifts digit_in into the display
//   start_btn         rising edge starts or resumes the countdown
//   cancel_btn        rising edge aborts from any state and clears the time
//   door_open         level, 1 = door open
//   sec_ones..min_tens BCD display digits (Hex0..Hex3)
//   heater_on         heater enable, only while running with the door closed
//   beep              alarm, held for BEEP_SECS ticks after the time expires
//   state[2:0]        FSM state for debug: IDLE=0 ENTRY=1 RUN=2 PAUSE=3 DONE=4
//
// No valid/ready handshakes: the buttons are edge-detected levels and
// tick_1hz is a single-cycle strobe that is acted on only in the cycle it is
// high.
// ---------------------------------------------------------------------------
module oven_timer_ctrl #(
  parameter int BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [3:0] digit_in,
  input  logic       enter_btn,
  input  logic       start_btn,
  input  logic       cancel_btn,
  input  logic       door_open,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       heater_on,
  output logic       beep,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ENTRY = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] BEEP_LAST = 4'(BEEP_SECS - 1);

  logic [2:0] stateReg, stateNext;
  logic [3:0] secOnesReg, secTensReg, minOnesReg, minTensReg;
  logic [3:0] secOnesNext, secTensNext, minOnesNext, minTensNext;
  logic [3:0] secOnesDec, secTensDec, minOnesDec, minTensDec;
  logic       beepReg, beepNext;
  logic [3:0] beepCnt, beepCntNext;
  logic       enterPrev, startPrev, cancelPrev;
  logic       enterRise, startRise, cancelRise;
  logic       timeIsZero, timeIsOne, digitOk, startOk;

  assign enterRise  = enter_btn  & ~enterPrev;
  assign startRise  = start_btn  & ~startPrev;
  assign cancelRise = cancel_btn & ~cancelPrev;

  assign timeIsZero = (minTensReg == 4'd0) && (minOnesReg == 4'd0) &&
                      (secTensReg == 4'd0) && (secOnesReg == 4'd0);
  assign timeIsOne  = (minTensReg == 4'd0) && (minOnesReg == 4'd0) &&
                      (secTensReg == 4'd0) && (secOnesReg == 4'd1);
  assign digitOk    = (digit_in <= 4'd9);
  // Entry accepts tens-of-seconds up to 9, so a bad seconds field is caught here.
  assign startOk    = !timeIsZero && (secTensReg <= 4'd5) && !door_open;

  // One-second BCD decrement with borrow. Never evaluated at 00:00 because
  // the 00:01 tick leaves RUN.
  always_comb begin
    secOnesDec = secOnesReg;
    secTensDec = secTensReg;
    minOnesDec = minOnesReg;
    minTensDec = minTensReg;
    if (secOnesReg != 4'd0) begin
      secOnesDec = secOnesReg - 4'd1;
    end else begin
      secOnesDec = 4'd9;
      if (secTensReg != 4'd0) begin
        secTensDec = secTensReg - 4'd1;
      end else begin
        secTensDec = 4'd5;
        if (minOnesReg != 4'd0) begin
          minOnesDec = minOnesReg - 4'd1;
        end else begin
          minOnesDec = 4'd9;
          minTensDec = minTensReg - 4'd1;
        end
      end
    end
  end

  // State register plus the datapath registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      secOnesReg <= 4'd0;
      secTensReg <= 4'd0;
      minOnesReg <= 4'd0;
      minTensReg <= 4'd0;
      beepReg    <= 1'b0;
      beepCnt    <= 4'd0;
      // Held buttons must not look like a fresh press after reset release.
      enterPrev  <= 1'b1;
      startPrev  <= 1'b1;
      cancelPrev <= 1'b1;
    end else begin
      stateReg   <= stateNext;
      secOnesReg <= secOnesNext;
      secTensReg <= secTensNext;
      minOnesReg <= minOnesNext;
      minTensReg <= minTensNext;
      beepReg    <= beepNext;
      beepCnt    <= beepCntNext;
      enterPrev  <= enter_btn;
      startPrev  <= start_btn;
      cancelPrev <= cancel_btn;
    end
  end

  // Next-state and datapath update. Priority: cancel > door > start > enter > tick.
  always_comb begin
    stateNext   = stateReg;
    secOnesNext = secOnesReg;
    secTensNext = secTensReg;
    minOnesNext = minOnesReg;
    minTensNext = minTensReg;
    beepNext    = beepReg;
    beepCntNext = beepCnt;
    if (cancelRise) begin
      stateNext   = IDLE;
      secOnesNext = 4'd0;
      secTensNext = 4'd0;
      minOnesNext = 4'd0;
      minTensNext = 4'd0;
      beepNext    = 1'b0;
      beepCntNext = 4'd0;
    end else begin
      case (stateReg)
        IDLE, ENTRY: begin
          if ((stateReg == ENTRY) && startRise) begin
            // A start press takes precedence over enter even when refused.
            if (startOk) stateNext = RUN;
          end else if (enterRise && digitOk) begin
            minTensNext = minOnesReg;
            minOnesNext = secTensReg;
            secTensNext = secOnesReg;
            secOnesNext = digit_in;
            stateNext   = ENTRY;
          end
        end
        RUN: begin
          if (door_open) begin
            stateNext = PAUSE;
          end else if (tick_1hz) begin
            secOnesNext = secOnesDec;
            secTensNext = secTensDec;
            minOnesNext = minOnesDec;
            minTensNext = minTensDec;
            if (timeIsOne) begin
              stateNext   = DONE;
              beepNext    = 1'b1;
              beepCntNext = 4'd0;
            end
          end
        end
        PAUSE: begin
          if (startRise && !door_open) stateNext = RUN;
        end
        DONE: begin
          if (startRise || enterRise) begin
            stateNext   = IDLE;
            beepNext    = 1'b0;
            beepCntNext = 4'd0;
          end else if (tick_1hz) begin
            if (beepCnt == BEEP_LAST) begin
              stateNext   = IDLE;
              beepNext    = 1'b0;
              beepCntNext = 4'd0;
            end else begin
              beepCntNext = beepCnt + 4'd1;
            end
          end
        end
        default: begin
          stateNext   = IDLE;
          secOnesNext = 4'd0;
          secTensNext = 4'd0;
          minOnesNext = 4'd0;
          minTensNext = 4'd0;
          beepNext    = 1'b0;
          beepCntNext = 4'd0;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    state     = stateReg;
    sec_ones  = secOnesReg;
    sec_tens  = secTensReg;
    min_ones  = minOnesReg;
    min_tens  = minTensReg;
    beep      = beepReg;
    heater_on = (stateReg == RUN) & ~door_open;
  end

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oven_timer_ctrl
//   Directed walk through the oven timer's scenarios followed by a random
//   phase. A reference model keeps the running time as a plain count of
//   seconds and the typed digits as a four-entry shift list, and every cycle
//   the DUT's display, state, heater and beep are compared to it.
// ---------------------------------------------------------------------------
module tb_oven_timer_ctrl;

  localparam int BEEP_SECS = 3;

  // ---- clock / reset -------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter_btn = 1'b0;
  logic       start_btn = 1'b0;
  logic       cancel_btn = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       heater_on, beep;
  logic [2:0] state;

  always #5 clk = ~clk;

  oven_timer_ctrl #(.BEEP_SECS(BEEP_SECS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .digit_in(digit_in),
    .enter_btn(enter_btn), .start_btn(start_btn), .cancel_btn(cancel_btn),
    .door_open(door_open), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .heater_on(heater_on),
    .beep(beep), .state(state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---- reference model -----------------------------------------------------
  // m_dig[0..3] = min_tens, min_ones, sec_tens, sec_ones as shown on Hex3..Hex0.
  int   m_state;
  int   m_dig[4];
  int   m_secs;
  int   m_beep;
  int   m_ticks_in_done;
  logic m_prev_start, m_prev_enter, m_prev_cancel;

  function automatic logic [15:0] exp_disp();
    return {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_secs = 0;
    m_beep = 0;
    m_ticks_in_done = 0;
    m_prev_start = 1'b1;
    m_prev_enter = 1'b1;
    m_prev_cancel = 1'b1;
  endtask

  task automatic show_secs();
    m_dig[0] = (m_secs / 60) / 10;
    m_dig[1] = (m_secs / 60) % 10;
    m_dig[2] = (m_secs % 60) / 10;
    m_dig[3] = (m_secs % 60) % 10;
  endtask

  task automatic model_edge(input logic t, input logic s, input logic e,
                            input logic c, input logic d, input logic [3:0] din);
    logic sr, er, cr;
    sr = s & ~m_prev_start;
    er = e & ~m_prev_enter;
    cr = c & ~m_prev_cancel;
    m_prev_start = s;
    m_prev_enter = e;
    m_prev_cancel = c;
    if (cr) begin
      m_state = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_secs = 0;
      m_beep = 0;
      m_ticks_in_done = 0;
    end else begin
      case (m_state)
        0, 1: begin
          if (m_state == 1 && sr) begin
            if ((m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) != 0 && m_dig[2] <= 5 && !d) begin
              m_secs = (m_dig[0] * 10 + m_dig[1]) * 60 + m_dig[2] * 10 + m_dig[3];
              m_state = 2;
            end
          end else if (er && din <= 9) begin
            m_dig[0] = m_dig[1];
            m_dig[1] = m_dig[2];
            m_dig[2] = m_dig[3];
            m_dig[3] = int'(din);
            m_state = 1;
          end
        end
        2: begin
          if (d) m_state = 3;
          else if (t) begin
            m_secs = m_secs - 1;
            show_secs();
            if (m_secs == 0) begin
              m_state = 4;
              m_beep = 1;
              m_ticks_in_done = 0;
            end
          end
        end
        3: if (sr && !d) m_state = 2;
        4: begin
          if (sr || er) begin
            m_state = 0;
            m_beep = 0;
          end else if (t) begin
            m_ticks_in_done++;
            if (m_ticks_in_done == BEEP_SECS) begin
              m_state = 0;
              m_beep = 0;
            end
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  // ---- checking ------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("display", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, {16'd0, exp_disp()});
    check("state", {29'd0, state}, 32'(m_state));
    check("heater", {31'd0, heater_on}, {31'd0, (m_state == 2) && !door_open});
    check("beep", {31'd0, beep}, 32'(m_beep));
  endtask

  // ---- driver tasks --------------------------------------------------------
  // Inputs change at the falling edge, DUT samples at the rising edge, and
  // outputs are compared at the following falling edge.
  task automatic step(input logic t, input logic s, input logic e,
                      input logic c, input logic d, input logic [3:0] din);
    tick_1hz = t;
    start_btn = s;
    enter_btn = e;
    cancel_btn = c;
    door_open = d;
    digit_in = din;
    @(posedge clk);
    model_edge(t, s, e, c, d, din);
    @(negedge clk);
    check_model();
  endtask

  task automatic tap_enter(input logic [3:0] din);
    step(0, 0, 1, 0, 0, din);
    step(0, 0, 0, 0, 0, din);
  endtask

  task automatic tap_start(input logic d);
    step(0, 1, 0, 0, d, 4'd0);
    step(0, 0, 0, 0, d, 4'd0);
  endtask

  task automatic tap_cancel();
    step(0, 0, 0, 1, 0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic tick(input logic d);
    step(1, 0, 0, 0, d, 4'd0);
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    tap_cancel();
    tap_enter(a);
    tap_enter(b);
    tap_enter(c);
    tap_enter(d);
  endtask

  function automatic logic [31:0] disp32();
    return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // ---- stimulus ------------------------------------------------------------
  initial begin
    logic r_tick, r_start, r_enter, r_cancel, r_door;
    logic [3:0] r_digit;

    // 1: enter held through reset release must not register as a press.
    model_reset();
    enter_btn = 1'b1;
    digit_in = 4'd1;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_display", disp32(), 32'h0000);
    check("rst_beep", {31'd0, beep}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 4'd1);
    check("held_enter_state", {29'd0, state}, 32'd0);
    check("held_enter_display", disp32(), 32'h0000);
    step(0, 0, 0, 0, 0, 4'd1);

    // 2: 1,3,(12 ignored),0 -> 01:30, start, five ticks -> 01:25.
    tap_enter(4'd1);
    tap_enter(4'd3);
    tap_enter(4'd12);
    tap_enter(4'd0);
    check("entry_0130", disp32(), 32'h0130);
    check("entry_state", {29'd0, state}, 32'd1);
    step(0, 1, 0, 0, 0, 4'd0);
    check("run_state", {29'd0, state}, 32'd2);
    check("run_heater", {31'd0, heater_on}, 32'd1);
    step(0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick(0);
      step(0, 0, 0, 0, 0, 4'd0);
    end
    check("run_0125", disp32(), 32'h0125);

    // 3: borrow cases and the end of the countdown.
    load4(4'd0, 4'd1, 4'd0, 4'd0);
    tap_start(0);
    tick(0);
    check("borrow_0059", disp32(), 32'h0059);
    load4(4'd1, 4'd0, 4'd0, 4'd0);
    tap_start(0);
    tick(0);
    check("borrow_0959", disp32(), 32'h0959);
    load4(4'd0, 4'd0, 4'd0, 4'd1);
    tap_start(0);
    tick(0);
    check("done_display", disp32(), 32'h0000);
    check("done_state", {29'd0, state}, 32'd4);
    check("done_beep", {31'd0, beep}, 32'd1);
    tick(0);
    tick(0);
    check("beep_still_on", {31'd0, beep}, 32'd1);
    tick(0);
    check("beep_off", {31'd0, beep}, 32'd0);
    check("done_to_idle", {29'd0, state}, 32'd0);
    check("idle_display", disp32(), 32'h0000);

    // 4: door opens on the same cycle as a tick.
    tap_cancel();
    tap_enter(4'd4);
    tap_enter(4'd5);
    tap_start(0);
    step(1, 0, 0, 0, 1, 4'd0);
    check("pause_state", {29'd0, state}, 32'd3);
    check("pause_display", disp32(), 32'h0045);
    check("pause_heater", {31'd0, heater_on}, 32'd0);
    step(0, 0, 0, 0, 0, 4'd0);
    tick(0);
    check("closed_no_start", {29'd0, state}, 32'd3);
    check("pause_tick_ignored", disp32(), 32'h0045);
    tap_start(0);
    check("resume_state", {29'd0, state}, 32'd2);

    // 5: refused starts.
    tap_cancel();
    tap_enter(4'd0);
    tap_start(0);
    check("start_zero", {29'd0, state}, 32'd1);
    tap_enter(4'd7);
    tap_enter(4'd5);
    tap_start(0);
    check("start_0075", {29'd0, state}, 32'd1);
    check("start_0075_heater", {31'd0, heater_on}, 32'd0);

    // 6: cancel beats coincident tick and start; then async reset mid-run.
    tap_cancel();
    tap_enter(4'd2);
    tap_enter(4'd0);
    tap_start(0);
    step(1, 1, 0, 1, 0, 4'd0);
    check("cancel_state", {29'd0, state}, 32'd0);
    check("cancel_display", disp32(), 32'h0000);
    check("cancel_heater", {31'd0, heater_on}, 32'd0);
    step(0, 0, 0, 0, 0, 4'd0);
    tap_enter(4'd3);
    tap_enter(4'd0);
    tap_start(0);
    tick(0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", {29'd0, state}, 32'd0);
    check("async_display", disp32(), 32'h0000);
    check("async_heater", {31'd0, heater_on}, 32'd0);
    check("async_beep", {31'd0, beep}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 4'd0);

    // Random phase: small digits so countdowns reach DONE, rare cancel/door.
    r_start = 1'b0;
    r_enter = 1'b0;
    r_cancel = 1'b0;
    r_door = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) r_start = ~r_start;
      if ($urandom_range(0, 1) == 0) r_enter = ~r_enter;
      if ($urandom_range(0, 59) == 0) r_cancel = ~r_cancel;
      if ($urandom_range(0, 24) == 0) r_door = ~r_door;
      r_digit = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(0, 2));
      step(r_tick, r_start, r_enter, r_cancel, r_door, r_digit);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
